// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save accumulator: FSM state encoding and
// default widths used by csa_accumulator and its sub-blocks.
package csa_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_ACC_W  = 8;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/csa_row.sv
// One WIDTH-bit carry-save adder row: compresses three vectors into a
// sum vector and a carry vector (carries kept at their own bit weight).
module csa_row #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_s,
  input  logic [WIDTH-1:0] i_k,
  input  logic [WIDTH-1:0] i_x,
  output logic [WIDTH-1:0] o_s,
  output logic [WIDTH-1:0] o_c
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    full_adder u_fa (
      .a   (i_s[g]),
      .b   (i_k[g]),
      .cin (i_x[g]),
      .sum (o_s[g]),
      .cout(o_c[g])
    );
  end

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used by the CSA row and the serial resolver.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/csa_accumulator.sv
// Streaming accumulator holding its total in carry-save form, resolved
// bit-serially on the last operand. Optional macro: CSA_ACC_OVERFLOW_EN.
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy
`ifdef CSA_ACC_OVERFLOW_EN
  ,
  output logic              overflow
`endif
);

  localparam int IDX_W = (ACC_W > 1) ? $clog2(ACC_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ACC_W - 1);

  state_t             r_state;
  state_t             w_next;
  logic [ACC_W-1:0]   r_s;
  logic [ACC_W-1:0]   r_c;
  logic [ACC_W-1:0]   r_result;
  logic [CNT_W-1:0]   r_count;
  logic [IDX_W-1:0]   r_idx;
  logic               r_k;
  logic [ACC_W-1:0]   w_k;
  logic [ACC_W-1:0]   w_x;
  logic [ACC_W-1:0]   w_row_s;
  logic [ACC_W-1:0]   w_row_c;
  logic               w_fa_sum;
  logic               w_fa_cout;
  logic               w_accept;
  logic               w_take;

  // Carries are stored at their own weight; shifting left drops C's MSB.
  assign w_k      = r_c << 1;
  assign w_x      = ACC_W'(in_data);
  assign w_accept = in_valid && (r_state == ST_IDLE);
  assign w_take   = (r_state == ST_DONE) && out_ready;

  csa_row #(.WIDTH(ACC_W)) u_row (
    .i_s(r_s),
    .i_k(w_k),
    .i_x(w_x),
    .o_s(w_row_s),
    .o_c(w_row_c)
  );

  full_adder u_serial_fa (
    .a   (r_s[r_idx]),
    .b   (w_k[r_idx]),
    .cin (r_k),
    .sum (w_fa_sum),
    .cout(w_fa_cout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept && in_last) w_next = ST_RESOLVE;
      ST_RESOLVE: if (r_idx == LAST_IDX)   w_next = ST_DONE;
      ST_DONE:    if (out_ready)           w_next = ST_IDLE;
      default:                             w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s      <= '0;
      r_c      <= '0;
      r_result <= '0;
      r_count  <= '0;
      r_idx    <= '0;
      r_k      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_s     <= w_row_s;
            r_c     <= w_row_c;
            r_count <= r_count + 1'b1;
            r_idx   <= '0;
            r_k     <= 1'b0;
          end
        end
        ST_RESOLVE: begin
          r_result[r_idx] <= w_fa_sum;
          r_k             <= w_fa_cout;
          r_idx           <= r_idx + 1'b1;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_s      <= '0;
            r_c      <= '0;
            r_count  <= '0;
            r_result <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CSA_ACC_OVERFLOW_EN
  logic r_ovf;

  // Sticky: any weight-2^ACC_W bit thrown away means the true sum wrapped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_ovf <= 1'b0;
    else if (w_accept && r_c[ACC_W-1])
      r_ovf <= 1'b1;
    else if ((r_state == ST_RESOLVE) && (r_idx == LAST_IDX) && w_fa_cout)
      r_ovf <= 1'b1;
    else if (w_take)
      r_ovf <= 1'b0;
  end

  assign overflow = (r_state == ST_DONE) && r_ovf;
`endif

  // The bit-serial result is only exposed once fully resolved.
  assign in_ready  = (r_state == ST_IDLE) && !reset;
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign out_data  = out_valid ? r_result : '0;
  assign out_count = r_count;

endmodule

// File: tb/tb_csa_accumulator.sv
// Randomised self-checking bench for csa_accumulator; expected results come
// from a plain integer-sum model of each operand group.
module tb_csa_accumulator;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] out_count;
  logic       busy;
`ifdef CSA_ACC_OVERFLOW_EN
  logic       overflow;
`endif

  int n_vec = 0;
  int n_err = 0;
  int q_words[$];

  csa_accumulator dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count),
    .busy     (busy)
`ifdef CSA_ACC_OVERFLOW_EN
    ,
    .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] model_sum();
    int s = 0;
    foreach (q_words[i]) s += q_words[i];
    return 8'(s % 256);
  endfunction

  function automatic logic [7:0] model_count();
    return 8'(q_words.size() % 256);
  endfunction

  task automatic send_word(input logic [3:0] d, input logic last);
    int   tries = 0;
    logic acc   = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!acc && tries < 200) begin
      acc = in_ready;
      @(negedge clk);
      tries++;
    end
    if (!acc) begin
      n_err++;
      $display("[TB] FAIL accept_timeout: got no accept after %0d cycles expected accept of %0d", tries, d);
    end
  endtask

  task automatic drive_group(input bit gaps);
    for (int i = 0; i < q_words.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      send_word(4'(q_words[i]), i == q_words.size() - 1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result(output logic [7:0] d, output logic [7:0] c, output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) begin
      n_err++;
      $display("[TB] FAIL result_timeout: got out_valid=0 after %0d cycles expected 1", lat);
    end
    d = out_data;
    c = out_count;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (in_ready !== 1'b0)  begin n_err++; $display("[TB] FAIL rst_in_ready: got %b expected 0", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_vec++; if (out_data !== 8'd0)  begin n_err++; $display("[TB] FAIL rst_out_data: got %0d expected 0", out_data); end
    n_vec++; if (out_count !== 8'd0) begin n_err++; $display("[TB] FAIL rst_out_count: got %0d expected 0", out_count); end
    n_vec++; if (busy !== 1'b0)      begin n_err++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1)  begin n_err++; $display("[TB] FAIL idle_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [7:0] d, c; int lat;
    q_words = '{5, 7, 9};
    out_ready = 1'b1;
    drive_group(1'b0);
    wait_result(d, c, lat);
    n_vec++; if (d !== 8'd21)   begin n_err++; $display("[TB] FAIL basic_data: got %0d expected 21", d); end
    n_vec++; if (c !== 8'd3)    begin n_err++; $display("[TB] FAIL basic_count: got %0d expected 3", c); end
    n_vec++; if (lat !== 8)     begin n_err++; $display("[TB] FAIL basic_latency: got %0d expected 8", lat); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL done_in_ready: got %b expected 0", in_ready); end
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL basic_hs_valid: got %b expected 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1)  begin n_err++; $display("[TB] FAIL basic_hs_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_single();
    logic [7:0] d, c; int lat;
    q_words = '{15};
    out_ready = 1'b1;
    drive_group(1'b0);
    wait_result(d, c, lat);
    n_vec++; if (d !== 8'd15) begin n_err++; $display("[TB] FAIL single_data: got %0d expected 15", d); end
    n_vec++; if (c !== 8'd1)  begin n_err++; $display("[TB] FAIL single_count: got %0d expected 1", c); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [7:0] d, c; int lat;
    q_words = {};
    repeat (18) q_words.push_back(15);
    out_ready = 1'b1;
    drive_group(1'b0);
    wait_result(d, c, lat);
    n_vec++; if (d !== 8'd14) begin n_err++; $display("[TB] FAIL wrap18_data: got %0d expected 14", d); end
    n_vec++; if (c !== 8'd18) begin n_err++; $display("[TB] FAIL wrap18_count: got %0d expected 18", c); end
`ifdef CSA_ACC_OVERFLOW_EN
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("[TB] FAIL wrap18_ovf: got %b expected 1", overflow); end
`endif
    @(negedge clk);
    q_words = {};
    repeat (16) q_words.push_back(15);
    drive_group(1'b0);
    wait_result(d, c, lat);
    n_vec++; if (d !== 8'd240) begin n_err++; $display("[TB] FAIL wrap16_data: got %0d expected 240", d); end
`ifdef CSA_ACC_OVERFLOW_EN
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("[TB] FAIL wrap16_ovf: got %b expected 0", overflow); end
`endif
    @(negedge clk);
  endtask

  task automatic test_stall();
    logic [7:0] d, c, exp_d, exp_c; int lat;
    q_words = {};
    repeat ($urandom_range(1, 6)) q_words.push_back($urandom_range(0, 15));
    exp_d = model_sum(); exp_c = model_count();
    out_ready = 1'b0;
    drive_group(1'b1);
    wait_result(d, c, lat);
    n_vec++; if (d !== exp_d) begin n_err++; $display("[TB] FAIL stall_data: got %0d expected %0d", d, exp_d); end
    in_valid = 1'b1; in_data = 4'($urandom_range(1, 15)); in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++; if (out_data !== exp_d)  begin n_err++; $display("[TB] FAIL stall_hold_data: got %0d expected %0d", out_data, exp_d); end
      n_vec++; if (out_count !== exp_c) begin n_err++; $display("[TB] FAIL stall_hold_count: got %0d expected %0d", out_count, exp_c); end
      n_vec++; if (in_ready !== 1'b0)   begin n_err++; $display("[TB] FAIL stall_in_ready: got %b expected 0", in_ready); end
      n_vec++; if (out_valid !== 1'b1)  begin n_err++; $display("[TB] FAIL stall_out_valid: got %b expected 1", out_valid); end
    end
    out_ready = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL stall_release: got %b expected 0", out_valid); end
    q_words = {};
    repeat ($urandom_range(1, 6)) q_words.push_back($urandom_range(0, 15));
    exp_d = model_sum(); exp_c = model_count();
    drive_group(1'b0);
    wait_result(d, c, lat);
    n_vec++; if (d !== exp_d) begin n_err++; $display("[TB] FAIL stall_next_data: got %0d expected %0d", d, exp_d); end
    n_vec++; if (c !== exp_c) begin n_err++; $display("[TB] FAIL stall_next_count: got %0d expected %0d", c, exp_c); end
    @(negedge clk);
  endtask

  task automatic test_reset_resolve();
    logic [7:0] d, c; int lat;
    q_words = '{9, 13, 6};
    out_ready = 1'b1;
    drive_group(1'b0);
    repeat (3) @(negedge clk);
    n_vec++; if (out_data !== 8'd0) begin n_err++; $display("[TB] FAIL partial_data: got %0d expected 0", out_data); end
    n_vec++; if (busy !== 1'b1)     begin n_err++; $display("[TB] FAIL resolve_busy: got %b expected 1", busy); end
    reset = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_valid: got %b expected 0", out_valid); end
    n_vec++; if (out_count !== 8'd0) begin n_err++; $display("[TB] FAIL midrst_count: got %0d expected 0", out_count); end
    n_vec++; if (busy !== 1'b0)      begin n_err++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    q_words = '{1, 2};
    drive_group(1'b0);
    wait_result(d, c, lat);
    n_vec++; if (d !== 8'd3) begin n_err++; $display("[TB] FAIL postrst_data: got %0d expected 3", d); end
    n_vec++; if (c !== 8'd2) begin n_err++; $display("[TB] FAIL postrst_count: got %0d expected 2", c); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] d, c; int lat;
    out_ready = 1'b1;
    send_word(4'd3, 1'b0);
    send_word(4'd4, 1'b1);
    in_data = 4'd10; in_last = 1'b1;
    wait_result(d, c, lat);
    n_vec++; if (d !== 8'd7)  begin n_err++; $display("[TB] FAIL b2b_first_data: got %0d expected 7", d); end
    n_vec++; if (c !== 8'd2)  begin n_err++; $display("[TB] FAIL b2b_first_count: got %0d expected 2", c); end
    n_vec++; if (lat !== 8)   begin n_err++; $display("[TB] FAIL b2b_latency: got %0d expected 8", lat); end
    send_word(4'd10, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    wait_result(d, c, lat);
    n_vec++; if (d !== 8'd10) begin n_err++; $display("[TB] FAIL b2b_second_data: got %0d expected 10", d); end
    n_vec++; if (c !== 8'd1)  begin n_err++; $display("[TB] FAIL b2b_second_count: got %0d expected 1", c); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] d, c, exp_d, exp_c; int lat;
    for (int g = 0; g < 10; g++) begin
      q_words = {};
      repeat ($urandom_range(1, 25)) q_words.push_back($urandom_range(0, 15));
      exp_d = model_sum(); exp_c = model_count();
      out_ready = 1'b0;
      drive_group(1'b1);
      wait_result(d, c, lat);
      n_vec++; if (d !== exp_d) begin n_err++; $display("[TB] FAIL rand_data[%0d]: got %0d expected %0d", g, d, exp_d); end
      n_vec++; if (c !== exp_c) begin n_err++; $display("[TB] FAIL rand_count[%0d]: got %0d expected %0d", g, c, exp_c); end
      n_vec++; if (lat !== 8)   begin n_err++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected 8", g, lat); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_wrap();
    test_stall();
    test_reset_resolve();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
